dmem_wbuf_ctrl: RTL and testbench
=================================

# dmem_wbuf_ctrl

MEM-stage data-memory controller between the pipeline's EX/MEM outputs (mem_read, mem_write, data_adr, data_out) and a word-wide external memory with a req/ack handshake. It returns load data on data_in for the MEM/WB register. Stores are absorbed into a FIFO write buffer and drained in the background. Load misses and full-buffer stores assert mem_stall, which freezes every pipeline register and the PC.

## Interface
- WB_DEPTH, 4, write-buffer entries; power of 2, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- mem_read  in  1  load in MEM stage; held stable while mem_stall=1
- mem_write  in  1  store in MEM stage; held stable while mem_stall=1
- data_adr  in  32  byte address; word-aligned, compare uses [31:2]
- data_out  in  32  store data
- data_in  out  32  load data to MEM/WB
- mem_stall  out  1  combinational pipeline freeze
- ext_req  out  1  external request
- ext_we  out  1  1=write, 0=read
- ext_adr  out  32  external address
- ext_wdata  out  32  external write data
- ext_ack  in  1  transaction complete, sampled with ext_req=1
- ext_rdata  in  32  read data, valid with ext_ack on reads

## Operation
- FSM states: IDLE, RD, WR, RD_DONE.
  - IDLE→RD: read miss pending.
  - IDLE→WR: no read miss and buffer non-empty. Read miss has priority over drain.
  - RD→RD_DONE: on ext_ack. ext_rdata is captured into rdata_q.
  - WR→IDLE: on ext_ack. Head entry is popped.
  - RD_DONE→IDLE: unconditionally, after one cycle.
- ext_req=1 in RD and WR only.
  - ext_adr/ext_we/ext_wdata are held stable from the state register until ack.
  - In WR they carry the buffer head entry.
- Store, buffer not full: entry {data_adr, data_out} is pushed at the clock edge, no stall.
- Store, buffer full: mem_stall=1. The push happens at the first edge where the count is below WB_DEPTH.
- Load hit (address matches any valid entry): data_in = youngest matching entry, no stall, no external access.
- Load miss:
  - mem_stall=1 in IDLE, RD, and WR.
  - mem_stall=0 in RD_DONE, with data_in=rdata_q.
  - The miss is not re-issued in RD_DONE.
- Load miss during WR: the drain completes first, then IDLE→RD.
- Push and pop in the same cycle: both occur, count unchanged. Pointers wrap modulo WB_DEPTH.
- mem_read and mem_write both asserted: treated as a load, store dropped. Simulation assertion flags it.
- Otherwise, data_in holds rdata_q.
- Reset:
  - All outputs 0, rdata_q=0, buffer empty, state IDLE.
  - Reset mid-transaction drops ext_req on the following cycle and discards buffered stores. External memory must tolerate an abandoned request.

## Timing
- Load hit or store with space: 0 stall cycles.
- Load miss, IDLE start, ack in the L-th cycle of ext_req (L≥1): L+1 stall cycles. data_in is valid in the cycle after ack.
- Load miss arriving during a drain: adds the remaining drain cycles plus 1.
- Drain throughput: one entry per L+1 cycles (IDLE cycle between drains).
- Full-buffer store stalls until one edge after the pop: stall is combinational on the full flag.

## Configuration
- DMEM_WBUF_FWD_EN defined: store-to-load forwarding from the buffer as described above.
- Not defined:
  - No address compare. Any load with the buffer non-empty stalls: FSM drains the buffer (WR priority over RD) until empty, then issues the read.
  - Loads with an empty buffer behave as misses.

## Test plan
- Reset with ext_req high in RD, rst=0 one cycle → next cycle ext_req=0, mem_stall=0, data_in=0, buffer empty.
- Load 0x100, memory returns 0xDEADBEEF with L=3 → mem_stall high exactly 4 cycles, data_in=0xDEADBEEF in the following cycle, single ext read.
- Store 0x200←0x11111111, then store 0x200←0x22222222, then load 0x200 → with FWD_EN: data_in=0x22222222, 0 stall, no ext read. Without it: two ext writes in order, then ext read.
- WB_DEPTH=4, five back-to-back stores, ext_ack held low → fifth store stalls; ack on first drain → fifth store accepted one cycle after pop, entries drained in issue order.
- Buffer holds a store to 0x300, load 0x400 arrives in IDLE → ext read 0x400 issued before ext write 0x300 (FWD_EN), reversed order without.
- Load miss arriving in WR cycle 1 with L=2 → write acked, IDLE, RD, stall total 5 cycles, correct data_in.

Source files
------------

// File: rtl/dmem_wbuf_ctrl_if.sv
// rtl/dmem_wbuf_ctrl_if.sv - external word-memory req/ack bus between the controller and memory
interface dmem_wbuf_ctrl_if;
   logic        ext_req;
   logic        ext_we;
   logic [31:0] ext_adr;
   logic [31:0] ext_wdata;
   logic        ext_ack;
   logic [31:0] ext_rdata;

   modport master (
      output ext_req, ext_we, ext_adr, ext_wdata,
      input  ext_ack, ext_rdata
   );

   modport slave (
      input  ext_req, ext_we, ext_adr, ext_wdata,
      output ext_ack, ext_rdata
   );
endinterface

// File: rtl/dmem_wbuf_ctrl.sv
// rtl/dmem_wbuf_ctrl.sv - MEM-stage data memory controller with FIFO write buffer
// Define DMEM_WBUF_FWD_EN for store-to-load forwarding out of the write buffer.
module dmem_wbuf_ctrl #(
   parameter int unsigned WB_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic [31:0]            data_adr,
   input  logic [31:0]            data_out,
   output logic [31:0]            data_in,
   output logic                   mem_stall,
   dmem_wbuf_ctrl_if.master       ext
);

   localparam int unsigned PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WB_DEPTH);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RD      = 2'd1;
   localparam logic [1:0] S_WR      = 2'd2;
   localparam logic [1:0] S_RD_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      buf_adr_q [WB_DEPTH];
   logic [31:0]      buf_adr_d [WB_DEPTH];
   logic [31:0]      buf_dat_q [WB_DEPTH];
   logic [31:0]      buf_dat_d [WB_DEPTH];
   logic [31:0]      rdata_q, rdata_d;
   logic             req_q, req_d;
   logic             we_q, we_d;
   logic [31:0]      adr_q, adr_d;
   logic [31:0]      wdata_q, wdata_d;

   logic             buf_empty;
   logic             buf_full;
   logic             is_store;
   logic             push;
   logic             pop;
   logic             fwd_hit;
   logic [31:0]      fwd_data;
   logic             rd_miss;
   logic             rd_issue;

   assign buf_empty = (count_q == '0);
   assign buf_full  = (count_q == FULL_CNT);
   // A simultaneous load and store is served as a load; the store is dropped.
   assign is_store  = mem_write && !mem_read;
   assign push      = is_store && !buf_full;
   assign pop       = (state_q == S_WR) && ext.ext_ack;

`ifdef DMEM_WBUF_FWD_EN
   logic [PTR_W-1:0] scan_idx;

   // Walk oldest to youngest so the last match seen is the youngest store.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      scan_idx = rd_ptr_q;
      for (int k = 0; k < int'(WB_DEPTH); k++) begin
         scan_idx = rd_ptr_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) && (buf_adr_q[scan_idx][31:2] == data_adr[31:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = buf_dat_q[scan_idx];
         end
      end
      fwd_hit = fwd_hit && mem_read;
   end

   assign rd_miss  = mem_read && !fwd_hit;
   assign rd_issue = rd_miss;
`else
   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;
   assign rd_miss  = mem_read;
   // Without address compare the buffer must be empty before a read is safe.
   assign rd_issue = mem_read && buf_empty;
`endif

   assign mem_stall = (rd_miss && (state_q != S_RD_DONE)) || (is_store && buf_full);
   assign data_in   = fwd_hit ? fwd_data : rdata_q;

   assign ext.ext_req   = req_q;
   assign ext.ext_we    = we_q;
   assign ext.ext_adr   = adr_q;
   assign ext.ext_wdata = wdata_q;

   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      req_d   = req_q;
      we_d    = we_q;
      adr_d   = adr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (rd_issue) begin
               state_d = S_RD;
               req_d   = 1'b1;
               we_d    = 1'b0;
               adr_d   = data_adr;
               wdata_d = '0;
            end else if (!buf_empty) begin
               state_d = S_WR;
               req_d   = 1'b1;
               we_d    = 1'b1;
               adr_d   = buf_adr_q[rd_ptr_q];
               wdata_d = buf_dat_q[rd_ptr_q];
            end
         end
         S_RD: begin
            if (ext.ext_ack) begin
               state_d = S_RD_DONE;
               rdata_d = ext.ext_rdata;
               req_d   = 1'b0;
               adr_d   = '0;
            end
         end
         S_WR: begin
            if (ext.ext_ack) begin
               state_d = S_IDLE;
               req_d   = 1'b0;
               we_d    = 1'b0;
               adr_d   = '0;
               wdata_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      buf_adr_d = buf_adr_q;
      buf_dat_d = buf_dat_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push) begin
         buf_adr_d[wr_ptr_q] = data_adr;
         buf_dat_d[wr_ptr_q] = data_out;
         wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
         req_q    <= req_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         wdata_q  <= wdata_d;
      end
   end

   // Buffer contents need no reset: validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      buf_adr_q <= buf_adr_d;
      buf_dat_q <= buf_dat_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         assert (!(mem_read && mem_write))
         else $warning("dmem_wbuf_ctrl: load and store asserted together, store dropped");
      end
   end

endmodule

// File: tb/tb_dmem_wbuf_ctrl.sv
// tb/tb_dmem_wbuf_ctrl.sv - directed self-checking bench for dmem_wbuf_ctrl
module tb_dmem_wbuf_ctrl;

`ifdef DMEM_WBUF_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] data_adr = '0;
   logic [31:0] data_out = '0;
   logic [31:0] data_in;
   logic        mem_stall;

   dmem_wbuf_ctrl_if bus ();

   dmem_wbuf_ctrl #(.WB_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .data_adr  (data_adr),
      .data_out  (data_out),
      .data_in   (data_in),
      .mem_stall (mem_stall),
      .ext       (bus.master)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int lat = 1;
   int req_cyc = 0;
   int n_log = 0;
   logic        log_we  [64];
   logic [31:0] log_adr [64];
   logic [31:0] log_dat [64];
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[15:0], 16'hC0DE};
   endfunction

   // Memory model: ack in the lat-th cycle of ext_req, log every completed transaction.
   initial begin
      bus.ext_ack   = 1'b0;
      bus.ext_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.ext_req) begin
            req_cyc++;
            if (req_cyc >= lat) begin
               bus.ext_ack = 1'b1;
               if (n_log < 64) begin
                  log_we[n_log]  = bus.ext_we;
                  log_adr[n_log] = bus.ext_adr;
                  log_dat[n_log] = bus.ext_we ? bus.ext_wdata : mem_rd(bus.ext_adr);
               end
               n_log++;
               if (bus.ext_we) mem[bus.ext_adr] = bus.ext_wdata;
               else bus.ext_rdata = mem_rd(bus.ext_adr);
            end else begin
               bus.ext_ack = 1'b0;
            end
         end else begin
            req_cyc     = 0;
            bus.ext_ack = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic do_load(input logic [31:0] a, output int stalls, output logic [31:0] d);
      mem_read = 1'b1;
      data_adr = a;
      stalls   = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!mem_stall) break;
         stalls++;
         next();
      end
      d = data_in;
      next();
      mem_read = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] v, output int stalls);
      mem_write = 1'b1;
      data_adr  = a;
      data_out  = v;
      stalls    = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!mem_stall) break;
         stalls++;
         next();
      end
      next();
      mem_write = 1'b0;
   endtask

   task automatic chk_log(input string tag, input int idx, input logic we,
                          input logic [31:0] a, input logic [31:0] v);
      chk($sformatf("%s_we", tag), 32'(log_we[idx]), 32'(we));
      chk($sformatf("%s_adr", tag), log_adr[idx], a);
      chk($sformatf("%s_dat", tag), log_dat[idx], v);
   endtask

   initial begin
      int          st;
      int          b;
      logic [31:0] d;

      mem[32'h100] = 32'hDEADBEEF;

      // Power-on reset
      repeat (2) next();
      @(negedge clk);
      chk("rst_req", 32'(bus.ext_req), 0);
      chk("rst_stall", 32'(mem_stall), 0);
      chk("rst_din", data_in, 0);
      chk("rst_adr", bus.ext_adr, 0);
      next();
      rst = 1'b1;
      next();

      // Load miss from IDLE, L=3
      lat = 3;
      b = n_log;
      do_load(32'h100, st, d);
      chk("miss_stalls", st, 4);
      chk("miss_data", d, 32'hDEADBEEF);
      chk("miss_nlog", n_log - b, 1);
      chk_log("miss_log0", b, 1'b0, 32'h100, 32'hDEADBEEF);

      // Reset during a drain with a second store queued and a load waiting
      lat = 1000;
      b = n_log;
      do_store(32'h600, 32'h0000_00A6, st);
      do_store(32'h604, 32'h0000_00A7, st);
      mem_read = 1'b1;
      data_adr = 32'h500;
      @(negedge clk);
      chk("wrrst_stall", 32'(mem_stall), 1);
      chk("wrrst_req", 32'(bus.ext_req), 1);
      chk("wrrst_we", 32'(bus.ext_we), 1);
      chk("wrrst_adr", bus.ext_adr, 32'h600);
      next();
      rst = 1'b0;
      mem_read = 1'b0;
      next();
      @(negedge clk);
      chk("wrrst_req0", 32'(bus.ext_req), 0);
      chk("wrrst_stall0", 32'(mem_stall), 0);
      chk("wrrst_din0", data_in, 0);
      chk("wrrst_adr0", bus.ext_adr, 0);
      next();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next();
         @(negedge clk);
         chk($sformatf("wrrst_empty%0d", i), 32'(bus.ext_req), 0);
      end
      chk("wrrst_nlog", n_log - b, 0);

      // Reset while a read is outstanding
      next();
      mem_read = 1'b1;
      data_adr = 32'h500;
      next();
      @(negedge clk);
      chk("rdrst_req", 32'(bus.ext_req), 1);
      chk("rdrst_we", 32'(bus.ext_we), 0);
      chk("rdrst_adr", bus.ext_adr, 32'h500);
      next();
      rst = 1'b0;
      mem_read = 1'b0;
      next();
      @(negedge clk);
      chk("rdrst_req0", 32'(bus.ext_req), 0);
      next();
      rst = 1'b1;
      lat = 1;
      next();

      // Two stores to one address then a load of it
      b = n_log;
      do_store(32'h200, 32'h1111_1111, st);
      do_store(32'h200, 32'h2222_2222, st);
      do_load(32'h200, st, d);
      chk("fwd_data", d, 32'h2222_2222);
      chk("fwd_stalls", st, FWD ? 0 : 5);
      repeat (20) next();
      chk("fwd_nlog", n_log - b, FWD ? 2 : 3);
      chk_log("fwd_log0", b, 1'b1, 32'h200, 32'h1111_1111);
      chk_log("fwd_log1", b + 1, 1'b1, 32'h200, 32'h2222_2222);

      // Five back-to-back stores into a 4-entry buffer with ack held off
      lat = 1000;
      b = n_log;
      for (int i = 0; i < 4; i++) begin
         do_store(32'h700 + 32'(4 * i), 32'h7000_0001 + 32'(i), st);
         chk($sformatf("full_st%0d_stalls", i), st, 0);
      end
      mem_write = 1'b1;
      data_adr  = 32'h710;
      data_out  = 32'h7000_0005;
      @(negedge clk);
      chk("full_stall_a", 32'(mem_stall), 1);
      next();
      @(negedge clk);
      chk("full_stall_b", 32'(mem_stall), 1);
      next();
      lat = 1;
      @(negedge clk);
      chk("full_stall_c", 32'(mem_stall), 1);
      next();
      @(negedge clk);
      chk("full_ack_stall", 32'(mem_stall), 1);
      chk("full_ack", 32'(bus.ext_ack), 1);
      next();
      @(negedge clk);
      chk("full_after_pop", 32'(mem_stall), 0);
      next();
      mem_write = 1'b0;
      repeat (20) next();
      chk("full_nlog", n_log - b, 5);
      for (int i = 0; i < 5; i++)
         chk_log($sformatf("full_log%0d", i), b + i, 1'b1, 32'h700 + 32'(4 * i), 32'h7000_0001 + 32'(i));

      // Buffered store to 0x300, load miss to 0x400 in IDLE
      lat = 2;
      b = n_log;
      do_store(32'h300, 32'h0000_0033, st);
      do_load(32'h400, st, d);
      chk("prio_data", d, 32'h0400_C0DE);
      chk("prio_stalls", st, FWD ? 3 : 6);
      repeat (20) next();
      chk("prio_nlog", n_log - b, 2);
      if (FWD) begin
         chk_log("prio_log0", b, 1'b0, 32'h400, 32'h0400_C0DE);
         chk_log("prio_log1", b + 1, 1'b1, 32'h300, 32'h0000_0033);
      end else begin
         chk_log("prio_log0", b, 1'b1, 32'h300, 32'h0000_0033);
         chk_log("prio_log1", b + 1, 1'b0, 32'h400, 32'h0400_C0DE);
      end

      // Load miss arriving in the first WR cycle, L=2
      b = n_log;
      do_store(32'h800, 32'h0000_0088, st);
      next();
      chk("wrmiss_req", 32'(bus.ext_req), 1);
      chk("wrmiss_we", 32'(bus.ext_we), 1);
      chk("wrmiss_adr", bus.ext_adr, 32'h800);
      chk("wrmiss_wdata", bus.ext_wdata, 32'h0000_0088);
      do_load(32'h900, st, d);
      chk("wrmiss_stalls", st, 5);
      chk("wrmiss_data", d, 32'h0900_C0DE);
      repeat (5) next();
      chk("wrmiss_nlog", n_log - b, 2);
      chk_log("wrmiss_log0", b, 1'b1, 32'h800, 32'h0000_0088);
      chk_log("wrmiss_log1", b + 1, 1'b0, 32'h900, 32'h0900_C0DE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
